video_timing_ctrl: RTL and testbench
====================================

# video_timing_ctrl

Raster scheduler for the HDMI PMOD TMDS output path. Counts pixel clocks into a horizontal/vertical raster and tells the three TMDS channel encoders, cycle by cycle, what to send:
- control period (sync symbols);
- HDMI video preamble;
- video guard band;
- active video.

It also provides the pixel coordinates and the sync/data-enable flags that the pixel source and encoders consume.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels; must be ≥10 when preambles are compiled in
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- HSYNC_POL, 0, asserted level of hsync_o
- VSYNC_POL, 0, asserted level of vsync_o

Derived values:
- H_TOTAL = sum of the four H parameters; must be ≤4096.
- V_TOTAL = sum of the four V parameters; must be ≤4096.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, asynchronous, active-high
- en_i  in  1  advance raster by one pixel when high; all state holds when low
- x_o  out  12  current horizontal count, 0..H_TOTAL-1
- y_o  out  12  current vertical count, 0..V_TOTAL-1
- de_o  out  1  pixel is in active video
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- period_o  out  2  encoder period select: 0 = control, 1 = video preamble, 2 = video guard band, 3 = active video
- ctl_o  out  4  CTL3..CTL0 for channels 1/2 during control periods
- line_start_o  out  1  high while x_o==0
- frame_start_o  out  1  high while x_o==0 and y_o==0

## Operation
- Raster order per line: active [0, H_ACTIVE), then front porch, then sync, then back porch.
- Raster order per frame: active lines [0, V_ACTIVE), then front porch, then sync, then back porch.
- Horizontal counter h increments on each clk_i edge with en_i=1.
  - At H_TOTAL-1 it wraps to 0 and the vertical counter advances.
  - The vertical counter wraps from V_TOTAL-1 to 0.
- de_o = (h < H_ACTIVE) and (v < V_ACTIVE).
- hsync_o = HSYNC_POL for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); ~HSYNC_POL otherwise.
- vsync_o = VSYNC_POL for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); ~VSYNC_POL otherwise. vsync_o changes only at h==0.
- Next line: v_next = 0 if v==V_TOTAL-1, else v+1.
- Period schedule within each line:
  - ACTIVE (3): when de_o=1.
  - PREAMBLE (1): h in [H_TOTAL-10, H_TOTAL-3] and v_next < V_ACTIVE; ctl_o=4'b0001.
  - GUARD (2): h in {H_TOTAL-2, H_TOTAL-1} and v_next < V_ACTIVE; ctl_o=0.
  - CONTROL (0): all other pixels; ctl_o=0.
- Exactly 8 preamble and 2 guard pixels precede every active line, including line 0 after the wrap from V_TOTAL-1.
- Reset state:
  - h=0, v=V_ACTIVE (first front-porch line).
  - Outputs: x_o=0, y_o=V_ACTIVE, de_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL, period_o=0, ctl_o=0.
  - line_start_o=1, frame_start_o=0.
  - The first frame_start_o occurs at the first wrap to (0,0), so the encoders always see a full vertical blank first.
- Reset mid-operation forces the reset state immediately, independent of clk_i.
- en_i low holds every output at its current value, including pulses: line_start_o stays high while held at h==0.

## Timing
- All outputs are registers, with no combinational path from en_i to any output.
- All outputs are mutually aligned: in any cycle, de_o, syncs, period_o, ctl_o and the start flags describe pixel (x_o, y_o).
- Advance latency is one clock: the edge that samples en_i=1 presents the next pixel.
- Flags for the next pixel are computed from the next counter values and registered, so they do not lag x_o/y_o.
- Counter arithmetic is 12-bit unsigned. Comparisons use the parameters resolved at elaboration. There is no run-time reconfiguration.

## Configuration
- Macro: HDMI_PREAMBLE_EN.
- Defined: PREAMBLE and GUARD periods are scheduled as above, and H_BP < 10 is an elaboration error.
- Undefined (DVI mode):
  - period_o is only 0 or 3 and ctl_o is constant 0.
  - The preamble/guard logic is absent and H_BP has no minimum.
  - All other behaviour is identical.

## Test plan
Small raster for all cases: H 16/2/4/12 (H_TOTAL=34), V 4/1/2/1 (V_TOTAL=8), polarities 0, en_i=1 unless stated.
- Reset: assert rst_i mid-line. Required immediately, without a clock edge: x_o=0, y_o=4, de_o=0, hsync_o=1, vsync_o=1, period_o=0. First frame_start_o after release comes 4×34=136 clocks later.
- Line scan on y=1:
  - de_o=1 for x=0..15.
  - hsync_o=0 for x=18..21.
  - period_o=1 with ctl_o=4'b0001 for x=24..31.
  - period_o=2 for x=32,33.
- Vertical wrap: on y=7, x=24..33 carry preamble/guard and the next cycle shows frame_start_o=1, de_o=1 at (0,0). y=3 carries no preamble/guard; y=5,6 show vsync_o=0 on all 34 pixels.
- Stall: drop en_i for 5 cycles at x=25, y=2. Required: outputs frozen (period_o=1), then resume at x=26 with no skipped pixel.
- DVI build (macro undefined): full frame; period_o is never 1 or 2 and ctl_o is always 0. Counts: de_o high 64 of 272 cycles, period_o==3 in exactly those cycles.

Source files
------------

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl
// Brief    : Raster scheduler for the HDMI TMDS path. It produces pixel
//            coordinates, sync and data-enable flags, and the per-pixel
//            encoder period (control / preamble / guard / active).
//            Optional macro HDMI_PREAMBLE_EN adds the video preamble and
//            guard band; without it the block runs in DVI mode.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [1:0]  period_o,
    output logic [3:0]  ctl_o,
    output logic        line_start_o,
    output logic        frame_start_o
);

    localparam int unsigned c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit compare constants so an edge equal to 4096 does not alias to 0
    localparam logic [11:0] c_H_LAST     = 12'(c_H_TOTAL - 1);
    localparam logic [11:0] c_V_LAST     = 12'(c_V_TOTAL - 1);
    localparam logic [12:0] c_H_ACT      = 13'(H_ACTIVE);
    localparam logic [12:0] c_V_ACT      = 13'(V_ACTIVE);
    localparam logic [12:0] c_HS_START   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] c_HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] c_VS_START   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] c_VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] c_V_RESET    = 12'(V_ACTIVE);

    localparam logic [1:0]  c_PERIOD_CTRL     = 2'd0;
    localparam logic [1:0]  c_PERIOD_ACTIVE   = 2'd3;

`ifdef HDMI_PREAMBLE_EN
    localparam logic [1:0]  c_PERIOD_PREAMBLE = 2'd1;
    localparam logic [1:0]  c_PERIOD_GUARD    = 2'd2;
    localparam logic [12:0] c_PRE_START       = 13'(c_H_TOTAL - 10);
    localparam logic [12:0] c_GUARD_START     = 13'(c_H_TOTAL - 2);
    localparam logic [3:0]  c_CTL_PREAMBLE    = 4'b0001;
`endif

    generate
        if (c_H_TOTAL > 4096 || c_V_TOTAL > 4096) begin : g_total_check
            $error("video_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 4096");
        end
`ifdef HDMI_PREAMBLE_EN
        if (H_BP < 10) begin : g_hbp_check
            $error("video_timing_ctrl: H_BP must be >= 10 when preambles are enabled");
        end
`endif
    endgenerate

    logic [11:0] r_h;
    logic [11:0] r_v;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic [1:0]  r_period;
    logic [3:0]  r_ctl;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_h_wrap;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;
    logic [12:0] w_h13;
    logic [12:0] w_v13;
    logic        w_de;
    logic        w_hsync;
    logic        w_vsync;
    logic [1:0]  w_period;
    logic [3:0]  w_ctl;

    // Next-pixel position; all flags below describe this position
    assign w_h_wrap = (r_h == c_H_LAST);
    assign w_h_nxt  = w_h_wrap ? 12'd0 : r_h + 12'd1;
    assign w_v_nxt  = !w_h_wrap         ? r_v   :
                      (r_v == c_V_LAST) ? 12'd0 : r_v + 12'd1;

    assign w_h13    = {1'b0, w_h_nxt};
    assign w_v13    = {1'b0, w_v_nxt};

    assign w_de     = (w_h13 < c_H_ACT) && (w_v13 < c_V_ACT);
    assign w_hsync  = ((w_h13 >= c_HS_START) && (w_h13 < c_HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign w_vsync  = ((w_v13 >= c_VS_START) && (w_v13 < c_VS_END)) ? VSYNC_POL : ~VSYNC_POL;

`ifdef HDMI_PREAMBLE_EN
    logic [11:0] w_line_after;
    logic        w_line_after_active;

    // Preamble/guard lead into the line after the one being scanned
    assign w_line_after        = (w_v_nxt == c_V_LAST) ? 12'd0 : w_v_nxt + 12'd1;
    assign w_line_after_active = ({1'b0, w_line_after} < c_V_ACT);
`endif

    always_comb begin
        w_period = c_PERIOD_CTRL;
        w_ctl    = 4'd0;
        if (w_de) begin
            w_period = c_PERIOD_ACTIVE;
        end
`ifdef HDMI_PREAMBLE_EN
        else if (w_line_after_active) begin
            if (w_h13 >= c_GUARD_START) begin
                w_period = c_PERIOD_GUARD;
            end else if (w_h13 >= c_PRE_START) begin
                w_period = c_PERIOD_PREAMBLE;
                w_ctl    = c_CTL_PREAMBLE;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_h           <= 12'd0;
            r_v           <= c_V_RESET;
            r_de          <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_period      <= c_PERIOD_CTRL;
            r_ctl         <= 4'd0;
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (en_i) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_de          <= w_de;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_period      <= w_period;
            r_ctl         <= w_ctl;
            r_line_start  <= (w_h_nxt == 12'd0);
            r_frame_start <= (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
        end
    end

    assign x_o           = r_h;
    assign y_o           = r_v;
    assign de_o          = r_de;
    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign period_o      = r_period;
    assign ctl_o         = r_ctl;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_ctrl
// Brief    : Self-checking bench for video_timing_ctrl on a 34x8 raster,
//            with a frame-position reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_ctrl;

    localparam int c_HA = 16, c_HF = 2, c_HS = 4, c_HB = 12;
    localparam int c_VA = 4,  c_VF = 1, c_VS = 2, c_VB = 1;
    localparam int c_HT = c_HA + c_HF + c_HS + c_HB;
    localparam int c_VT = c_VA + c_VF + c_VS + c_VB;
    localparam int c_FRAME = c_HT * c_VT;

`ifdef HDMI_PREAMBLE_EN
    localparam bit c_PRE = 1'b1;
`else
    localparam bit c_PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [11:0] x_o, y_o;
    logic        de_o, hsync_o, vsync_o, line_start_o, frame_start_o;
    logic [1:0]  period_o;
    logic [3:0]  ctl_o;

    int checks = 0;
    int errors = 0;

    video_timing_ctrl #(
        .H_ACTIVE(c_HA), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_ACTIVE(c_VA), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .x_o(x_o), .y_o(y_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .period_o(period_o), .ctl_o(ctl_o),
        .line_start_o(line_start_o), .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels advanced since reset, mapped onto the frame
    int n_adv = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) n_adv <= 0;
        else if (en) n_adv <= n_adv + 1;
    end

    always @(negedge clk) begin
        int pos, h, v, vn, per;
        pos = (c_VA * c_HT + n_adv) % c_FRAME;
        h   = pos % c_HT;
        v   = pos / c_HT;
        vn  = (v + 1) % c_VT;
        if (h < c_HA && v < c_VA)                           per = 3;
        else if (c_PRE && vn < c_VA && h >= c_HT - 10 && h <= c_HT - 3) per = 1;
        else if (c_PRE && vn < c_VA && h >= c_HT - 2)       per = 2;
        else                                                per = 0;
        chk("model_x", x_o, h);
        chk("model_y", y_o, v);
        chk("model_de", de_o, (per == 3) ? 1 : 0);
        chk("model_hsync", hsync_o, (h >= c_HA + c_HF && h < c_HA + c_HF + c_HS) ? 0 : 1);
        chk("model_vsync", vsync_o, (v >= c_VA + c_VF && v < c_VA + c_VF + c_VS) ? 0 : 1);
        chk("model_period", period_o, per);
        chk("model_ctl", ctl_o, (per == 1) ? 1 : 0);
        chk("model_line_start", line_start_o, (h == 0) ? 1 : 0);
        chk("model_frame_start", frame_start_o, (h == 0 && v == 0) ? 1 : 0);
    end

    task automatic wait_pix(input int x, input int y);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (x_o == 12'(x) && y_o == 12'(y)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_pix_reached", found, 1);
    endtask

    task automatic frame_start_latency();
        int k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            k++;
            if (frame_start_o) break;
        end
        chk("first_frame_start_clocks", k, 136);
    endtask

    initial begin
        int n_de, n_p3, n_pre, n_grd, n_ctl;

        repeat (3) @(negedge clk);
        chk("reset_x", x_o, 0);
        chk("reset_y", y_o, 4);
        chk("reset_line_start", line_start_o, 1);
        chk("reset_frame_start", frame_start_o, 0);
        rst = 1'b0;
        frame_start_latency();

        // Line scan on y=1 against hand-derived ranges
        wait_pix(0, 1);
        for (int x = 0; x < c_HT; x++) begin
            int ep;
            chk("scan_de", de_o, (x <= 15) ? 1 : 0);
            chk("scan_hsync", hsync_o, (x >= 18 && x <= 21) ? 0 : 1);
            if (x <= 15)                      ep = 3;
            else if (c_PRE && x >= 24 && x <= 31) ep = 1;
            else if (c_PRE && x >= 32)        ep = 2;
            else                              ep = 0;
            chk("scan_period", period_o, ep);
            chk("scan_ctl", ctl_o, (ep == 1) ? 1 : 0);
            @(negedge clk);
        end

        // Stall mid-preamble
        wait_pix(25, 2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_x", x_o, 25);
            chk("stall_y", y_o, 2);
            chk("stall_period", period_o, c_PRE ? 1 : 0);
            chk("stall_ctl", ctl_o, c_PRE ? 1 : 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("resume_x", x_o, 26);

        // y=3 precedes a blank line: no preamble/guard
        wait_pix(0, 3);
        for (int x = 0; x < c_HT; x++) begin
            chk("y3_no_pre", (period_o == 2'd1 || period_o == 2'd2) ? 1 : 0, 0);
            @(negedge clk);
        end

        // y=5,6 carry vsync on every pixel
        wait_pix(0, 5);
        for (int i = 0; i < 2 * c_HT; i++) begin
            chk("vsync_lines", vsync_o, 0);
            @(negedge clk);
        end

        // Vertical wrap from y=7 into line 0
        wait_pix(24, 7);
        for (int x = 24; x < c_HT; x++) begin
            chk("wrap_period", period_o, !c_PRE ? 0 : (x <= 31) ? 1 : 2);
            @(negedge clk);
        end
        chk("wrap_x", x_o, 0);
        chk("wrap_y", y_o, 0);
        chk("wrap_frame_start", frame_start_o, 1);
        chk("wrap_de", de_o, 1);

        // Asynchronous reset mid-line
        wait_pix(10, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", x_o, 0);
        chk("arst_y", y_o, 4);
        chk("arst_de", de_o, 0);
        chk("arst_hsync", hsync_o, 1);
        chk("arst_vsync", vsync_o, 1);
        chk("arst_period", period_o, 0);
        @(negedge clk);
        rst = 1'b0;
        frame_start_latency();

        // Full-frame statistics
        n_de = 0; n_p3 = 0; n_pre = 0; n_grd = 0; n_ctl = 0;
        for (int i = 0; i < c_FRAME; i++) begin
            if (de_o) n_de++;
            if (period_o == 2'd3) n_p3++;
            if (period_o == 2'd1) n_pre++;
            if (period_o == 2'd2) n_grd++;
            if (ctl_o != 4'd0) n_ctl++;
            @(negedge clk);
        end
        chk("frame_de_count", n_de, 64);
        chk("frame_active_count", n_p3, 64);
        chk("frame_preamble_count", n_pre, c_PRE ? 32 : 0);
        chk("frame_guard_count", n_grd, c_PRE ? 8 : 0);
        chk("frame_ctl_count", n_ctl, c_PRE ? 32 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
